adder12s_frame_ctrl: RTL
========================

Name: adder12s_frame_ctrl

Overview:
Sequencer for the 8-input, 12-bit signed pipelined adder tree (5 register stages, 15-bit sum). Accepts a serial stream of 12-bit signed samples with a valid/ready handshake and packs them 8 at a time into the adder's operand vector. It tracks each issued group through the adder latency and accumulates GROUPS adder results into one frame total, presented on a valid/ready output.

Parameters:
GROUPS, 4, adder groups (8 samples each) per frame; >=1
ADD_LAT, 5, adder register stages between operands and sum
ACC_W, 15+$clog2(GROUPS), frame accumulator/output width (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  sample valid
in_ready  out  1  controller can take a sample
in_data  in  12  signed sample
add_vec  out  96  adder operands; n0=[11:0] ... n7=[95:84]
add_sum  in  15  signed adder result
out_valid  out  1  frame total valid
out_ready  in  1  consumer accepts total
out_sum  out  ACC_W  signed frame total

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset: state=FILL, slot_cnt=0, grp_cnt=0, acc=0, valid shift register=0, add_vec=0, out_valid=0, out_sum=0, in_ready=1 in the cycle after reset.
- States: FILL, DRAIN, HOLD.
- FILL: in_ready=1. Transfer = in_valid&in_ready. Each transfer writes in_data to staging slot slot_cnt and increments slot_cnt (0..7).
- Issue: on the 8th transfer, staging slots 0..6 plus the current in_data are copied into add_vec as one register update. That cycle is the issue cycle. slot_cnt wraps to 0, a 1 enters bit 0 of the ADD_LAT+1 stage valid shift register, and grp_cnt increments.
- add_vec changes only at issue and is otherwise held.
- Capture: add_sum is sampled in the cycle ADD_LAT+1 after the issue cycle (shift register tap). At that clock edge, acc <= acc + sign-extended add_sum.
- Group spacing is at least 8 cycles and ADD_LAT+1 <= 8, so at most one group is in flight.
- If the issue is for group GROUPS-1: go to DRAIN, grp_cnt <= 0.
- DRAIN: in_ready=0. When the last capture occurs, go to HOLD and set out_sum = final acc value including that capture, registered.
- HOLD: out_valid=1; out_sum is stable. When out_ready=1: out_valid<=0, acc<=0, go to FILL.
- Backpressure: out_ready low holds HOLD indefinitely with in_ready=0 and no sample loss.
- Arithmetic: all signed, two's complement. ACC_W guarantees no overflow: range is GROUPS*8*[-2048, 2047].
- Reset mid-operation: the shift register is cleared, so in-flight adder results are ignored. Partial staging data is discarded and the next frame starts clean.
- GROUPS=1: the issue goes directly to DRAIN.

Optional Feature:
ADDER12S_CTRL_AVG_EN
- Defined: adds output out_avg [11:0], the frame mean rounded half up: (acc_final + 2^(k-1)) >>> k, with k = 3 + log2(GROUPS). Registered with out_sum and valid under the same out_valid. GROUPS must be a power of two; elaboration fails otherwise.
- Undefined: the port and its logic are absent.

Decomposition:
- Package adder12s_pkg: SAMPLE_W=12, LANES=8, SUM_W=15, ADD_LAT default, state enum {FILL, DRAIN, HOLD}, function acc_width(groups).
- One sub-module: adder12s_lat_track, the valid shift register producing the capture strobe.
- The adder tree is instantiated by the parent, not inside this block.

Test Plan:
1. GROUPS=4, 32 samples of +1 with continuous in_valid, out_ready=1 -> out_sum=32, out_valid for exactly one cycle. AVG_EN: out_avg=1.
2. Samples 1..32 in cycles 0..31 -> issue at cycles 7/15/23/31, first out_valid in cycle 38, out_sum=528. AVG_EN: out_avg=17.
3. 32 samples of -2048 -> out_sum=-65536; 32 samples of +2047 -> out_sum=65504; no wrap.
4. out_ready low for 10 cycles after out_valid -> out_sum stable, in_ready=0 throughout, next frame accepted after release and correct.
5. rst pulsed 3 cycles after the 2nd issue, then a full frame of +1 -> out_sum=32, not 48.
6. in_valid toggled randomly 50% -> totals match the reference model, add_vec changes only on issue cycles.

Source files
------------

// File: rtl/adder12s_pkg.sv
// adder12s_pkg: shared widths, state encoding and accumulator sizing for the adder12s frame controller
package adder12s_pkg;
    localparam int SAMPLE_W = 12;
    localparam int LANES = 8;
    localparam int SUM_W = 15;
    localparam int ADD_LAT_DEF = 5;
    typedef enum logic [1:0] {FILL = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_e;
    function automatic int acc_width(input int groups);
        return SUM_W + $clog2(groups);
    endfunction
endpackage

// File: rtl/adder12s_lat_track.sv
// adder12s_lat_track: delays each issue strobe through the adder latency to flag when add_sum is ready
module adder12s_lat_track import adder12s_pkg::*; #(
    parameter int DEPTH = ADD_LAT_DEF + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic capture
);
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else sr <= DEPTH'({sr, issue});
    end
    assign capture = sr[DEPTH-1];
endmodule

// File: rtl/adder12s_frame_ctrl.sv
// adder12s_frame_ctrl: packs samples into 8-lane adder groups and accumulates GROUPS results per frame
// Optional mean output out_avg when ADDER12S_CTRL_AVG_EN is defined.
module adder12s_frame_ctrl import adder12s_pkg::*; #(
    parameter int GROUPS = 4,
    parameter int ADD_LAT = ADD_LAT_DEF,
    localparam int ACC_W = acc_width(GROUPS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [SAMPLE_W-1:0]  in_data,
    output logic [LANES*SAMPLE_W-1:0]   add_vec,
    input  logic signed [SUM_W-1:0]     add_sum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_W-1:0]     out_sum
`ifdef ADDER12S_CTRL_AVG_EN
    ,output logic signed [SAMPLE_W-1:0] out_avg
`endif
);
    localparam logic [1:0] S_FILL = FILL;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_HOLD = HOLD;
    localparam int GRP_W = GROUPS > 1 ? $clog2(GROUPS) : 1;

    if (GROUPS < 1) begin : g_bad_groups
        $error("GROUPS must be at least 1");
    end
    // One group in flight at a time relies on the latency fitting inside the 8-sample spacing.
    if (ADD_LAT + 1 > LANES) begin : g_bad_lat
        $error("ADD_LAT+1 must not exceed the 8-cycle group spacing");
    end

    logic [1:0] state;
    logic [2:0] slot_cnt;
    logic [GRP_W-1:0] grp_cnt;
    logic [LANES-2:0][SAMPLE_W-1:0] stage;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic xfer, issue, capture, last_grp;

    assign in_ready = state == S_FILL;
    assign out_valid = state == S_HOLD;
    assign xfer = in_valid && in_ready;
    assign issue = xfer && slot_cnt == 3'(LANES - 1);
    assign last_grp = grp_cnt == GRP_W'(GROUPS - 1);
    assign acc_nxt = acc + ACC_W'(add_sum);

`ifdef ADDER12S_CTRL_AVG_EN
    localparam int K = 3 + $clog2(GROUPS);
    if ((1 << $clog2(GROUPS)) != GROUPS) begin : g_bad_pow2
        $error("GROUPS must be a power of two when the mean output is enabled");
    end
    logic signed [ACC_W:0] avg_rnd;
    assign avg_rnd = (ACC_W + 1)'(acc_nxt) + (ACC_W + 1)'(2 ** (K - 1));
`endif

    adder12s_lat_track #(.DEPTH(ADD_LAT + 1)) u_lat (
        .clk(clk),
        .rst(rst),
        .issue(issue),
        .capture(capture)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FILL;
            slot_cnt <= '0;
            grp_cnt <= '0;
            acc <= '0;
            add_vec <= '0;
            out_sum <= '0;
`ifdef ADDER12S_CTRL_AVG_EN
            out_avg <= '0;
`endif
        end else begin
            if (xfer) begin
                slot_cnt <= slot_cnt + 3'd1;
                if (!issue) stage[slot_cnt] <= in_data;
            end
            if (issue) begin
                add_vec <= {in_data, stage};
                grp_cnt <= last_grp ? '0 : grp_cnt + 1'b1;
                if (last_grp) state <= S_DRAIN;
            end
            if (capture) acc <= acc_nxt;
            // The only capture seen in DRAIN belongs to the final group of the frame.
            if (capture && state == S_DRAIN) begin
                state <= S_HOLD;
                out_sum <= acc_nxt;
`ifdef ADDER12S_CTRL_AVG_EN
                out_avg <= SAMPLE_W'(avg_rnd >>> K);
`endif
            end
            if (state == S_HOLD && out_ready) begin
                state <= S_FILL;
                acc <= '0;
            end
        end
    end
endmodule
